req_arbiter: RTL

REQ_ARBITER -- requirements
Module: req_arbiter

---
 rtl/req_arbiter_if.sv | 28 ++
 rtl/req_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/req_arbiter_if.sv
// req_arbiter_if: request, NoC handshake and ack bundle for req_arbiter.
interface req_arbiter_if #(
   parameter int NUM_FSM  = 4,
   parameter int SRC_ID_W = 4
);
   logic [NUM_FSM-1:0]  req_valid;
   logic [NUM_FSM-1:0]  req_is_mem;
   logic                ser_busy;
   logic                noc_ready;
   logic                ack_in;
   logic [SRC_ID_W-1:0] ack_src_id;
   logic [NUM_FSM-1:0]  arb_won;
   logic [NUM_FSM-1:0]  ack_out;
   logic                noc_valid;
   logic [SRC_ID_W-1:0] noc_src_id;
   logic                noc_is_mem;
   logic                busy;
   logic                err_bad_ack;
   logic                err_timeout;
   modport slave (
      input  req_valid, req_is_mem, ser_busy, noc_ready, ack_in, ack_src_id,
      output arb_won, ack_out, noc_valid, noc_src_id, noc_is_mem, busy, err_bad_ack, err_timeout
   );
   modport master (
      output req_valid, req_is_mem, ser_busy, noc_ready, ack_in, ack_src_id,
      input  arb_won, ack_out, noc_valid, noc_src_id, noc_is_mem, busy, err_bad_ack, err_timeout
   );
endinterface

// File: rtl/req_arbiter.sv
// req_arbiter: round-robin arbiter putting one of NUM_FSM request FSMs on a shared NoC port.
// Define REQ_ARB_TIMEOUT_EN to abort WAIT_ACK after TIMEOUT_CYCLES cycles without an ack.
module req_arbiter #(
   parameter int NUM_FSM        = 4,
   parameter int SRC_ID_W       = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic          clk,
   input logic          rst_n,
   req_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_FSM > 1) ? $clog2(NUM_FSM) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;
   state_t             r_state, w_state_nxt;
   logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt, r_sel, w_sel_nxt, w_pick, w_idx, w_sel_inc;
   logic               w_found, w_ack_match;
   logic               r_noc_valid, w_noc_valid_nxt, r_is_mem, w_is_mem_nxt;
   logic [NUM_FSM-1:0] r_arb_won, w_arb_won_nxt, r_ack_out, w_ack_out_nxt;
   logic               r_err_bad_ack, w_err_bad_ack_nxt;
`ifdef REQ_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic               r_err_timeout, w_err_timeout_nxt;
`endif
   // first requester at or above rr_ptr, wrapping
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int k = 0; k < NUM_FSM; k++) begin
         w_idx = PTR_W'((int'(r_rr_ptr) + k) % NUM_FSM);
         if (!w_found && bus.req_valid[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end
   assign w_sel_inc   = (r_sel == PTR_W'(NUM_FSM - 1)) ? '0 : r_sel + 1'b1;
   assign w_ack_match = bus.ack_in && (bus.ack_src_id == SRC_ID_W'(r_sel));
   always_comb begin
      w_state_nxt       = r_state;
      w_rr_ptr_nxt      = r_rr_ptr;
      w_sel_nxt         = r_sel;
      w_is_mem_nxt      = r_is_mem;
      w_noc_valid_nxt   = r_noc_valid;
      w_arb_won_nxt     = '0;
      w_ack_out_nxt     = '0;
      w_err_bad_ack_nxt = r_err_bad_ack | (bus.ack_in & ~((r_state == WAIT_ACK) & w_ack_match));
`ifdef REQ_ARB_TIMEOUT_EN
      w_cnt_nxt         = r_cnt;
      w_err_timeout_nxt = r_err_timeout;
`endif
      unique case (r_state)
         IDLE:
            if (w_found && !bus.ser_busy) begin
               w_state_nxt     = ISSUE;
               w_sel_nxt       = w_pick;
               w_is_mem_nxt    = bus.req_is_mem[w_pick];
               w_noc_valid_nxt = 1'b1;
               w_arb_won_nxt   = NUM_FSM'(1) << w_pick;
            end
         ISSUE:
            if (bus.noc_ready) begin
               w_state_nxt     = WAIT_ACK;
               w_noc_valid_nxt = 1'b0;
`ifdef REQ_ARB_TIMEOUT_EN
               w_cnt_nxt       = '0;
`endif
            end
         WAIT_ACK:
            if (w_ack_match) begin
               w_state_nxt   = IDLE;
               w_ack_out_nxt = NUM_FSM'(1) << r_sel;
               w_rr_ptr_nxt  = w_sel_inc;
            end
`ifdef REQ_ARB_TIMEOUT_EN
            else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_state_nxt       = IDLE;
               w_err_timeout_nxt = 1'b1;
               w_rr_ptr_nxt      = w_sel_inc;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
`endif
         default: w_state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_rr_ptr      <= '0;
         r_sel         <= '0;
         r_is_mem      <= 1'b0;
         r_noc_valid   <= 1'b0;
         r_arb_won     <= '0;
         r_ack_out     <= '0;
         r_err_bad_ack <= 1'b0;
`ifdef REQ_ARB_TIMEOUT_EN
         r_cnt         <= '0;
         r_err_timeout <= 1'b0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_rr_ptr      <= w_rr_ptr_nxt;
         r_sel         <= w_sel_nxt;
         r_is_mem      <= w_is_mem_nxt;
         r_noc_valid   <= w_noc_valid_nxt;
         r_arb_won     <= w_arb_won_nxt;
         r_ack_out     <= w_ack_out_nxt;
         r_err_bad_ack <= w_err_bad_ack_nxt;
`ifdef REQ_ARB_TIMEOUT_EN
         r_cnt         <= w_cnt_nxt;
         r_err_timeout <= w_err_timeout_nxt;
`endif
      end
   end
   assign bus.arb_won     = r_arb_won;
   assign bus.ack_out     = r_ack_out;
   assign bus.noc_valid   = r_noc_valid;
   assign bus.noc_src_id  = SRC_ID_W'(r_sel);
   assign bus.noc_is_mem  = r_is_mem;
   assign bus.busy        = (r_state != IDLE);
   assign bus.err_bad_ack = r_err_bad_ack;
`ifdef REQ_ARB_TIMEOUT_EN
   assign bus.err_timeout = r_err_timeout;
`else
   assign bus.err_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif
endmodule
